audio_effect_mixer: RTL and testbench

//  Parametrised effect dispatcher/mixer between the I2S receive and transmit paths of io_module.
//  Per received frame:
//  - truncates the N_CHANNELS samples to MEM_D_WIDTH and fans them out to N_EFFECTS effect slots

---
 rtl/audio_effect_mixer_pkg.sv | 32 +++
 rtl/audio_effect_mixer_if.sv | 32 +++
 rtl/audio_effect_mixer_sat_trunc.sv | 31 +++
 rtl/audio_effect_mixer.sv | 193 +++++++++++++++++++
 tb/tb_audio_effect_mixer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/audio_effect_mixer_pkg.sv
// audio_fx_pkg: shared types and helpers for audio_effect_mixer.
//   state_t      frame FSM states (IDLE, DISPATCH, WAIT, MIX, OUT)
//   acc_width()  mixing accumulator width for a given sample width / slot count
//   sat_max/min  signed saturation limits for a given sample width
//   DEF_SAT_*    saturation limits for the default 16-bit effect sample width
package audio_fx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    WAIT,
    MIX,
    OUT
  } state_t;

  // Dry sample plus every slot may be summed, so leave headroom for N_EFFECTS+1 terms.
  function automatic int unsigned acc_width(input int unsigned mem_w, input int unsigned n_eff);
    return mem_w + $clog2(n_eff + 2);
  endfunction

  function automatic int sat_max(input int unsigned mem_w);
    return (1 << (mem_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned mem_w);
    return -(1 << (mem_w - 1));
  endfunction

  localparam int DEF_SAT_MAX = sat_max(16);
  localparam int DEF_SAT_MIN = sat_min(16);

endpackage

// File: rtl/audio_effect_mixer_if.sv
// audio_effect_mixer_if: bus between the mixer and its effect slots.
//   eff_data_in   mixer -> slots  truncated frame, ch0 in LSBs
//   eff_dv        mixer -> slots  1-cycle start strobe per slot
//   eff_done      slots -> mixer  1-cycle done strobe per slot
//   eff_data_out  slots -> mixer  slot results (slot k at k*N_CHANNELS*MEM_D_WIDTH), valid with eff_done
// Modports: master (mixer side), slave (effect side).
interface audio_effect_mixer_if #(
  parameter int unsigned MEM_D_WIDTH = 16,
  parameter int unsigned N_CHANNELS  = 2,
  parameter int unsigned N_EFFECTS   = 4
);

  logic [N_CHANNELS*MEM_D_WIDTH-1:0]           eff_data_in;
  logic [N_EFFECTS-1:0]                        eff_dv;
  logic [N_EFFECTS-1:0]                        eff_done;
  logic [N_EFFECTS*N_CHANNELS*MEM_D_WIDTH-1:0] eff_data_out;

  modport master (
    output eff_data_in,
    output eff_dv,
    input  eff_done,
    input  eff_data_out
  );

  modport slave (
    input  eff_data_in,
    input  eff_dv,
    output eff_done,
    output eff_data_out
  );

endinterface

// File: rtl/audio_effect_mixer_sat_trunc.sv
// sat_trunc: combinational saturation of one channel's mix accumulator.
//   acc  in   ACC_W signed accumulator
//   out  out  D_WIDTH sample: saturated MEM_D_WIDTH value in the MSBs, zero padded below
module sat_trunc
  import audio_fx_pkg::*;
#(
  parameter int unsigned D_WIDTH     = 24,
  parameter int unsigned MEM_D_WIDTH = 16,
  parameter int unsigned ACC_W       = 19
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic [D_WIDTH-1:0]      out
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_max(MEM_D_WIDTH));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_min(MEM_D_WIDTH));

  logic [MEM_D_WIDTH-1:0] sat;

  always_comb begin
    if (acc > HI) begin
      sat = HI[MEM_D_WIDTH-1:0];
    end else if (acc < LO) begin
      sat = LO[MEM_D_WIDTH-1:0];
    end else begin
      sat = acc[MEM_D_WIDTH-1:0];
    end
    out = {sat, {(D_WIDTH - MEM_D_WIDTH){1'b0}}};
  end

endmodule

// File: rtl/audio_effect_mixer.sv
// audio_effect_mixer: dispatches each received I2S frame to N_EFFECTS effect slots,
// sums the dry signal and the selected slot results with saturation, and returns
// the mixed frame for playback.
//   clk, reset    clock; asynchronous active-high reset
//   in_data/in_dv received frame (ch0 in LSBs, signed) and its 1-cycle strobe
//   sel           bit0 dry enable, bit k slot k-1 enable (latched per frame)
//   fx            effect-slot bus (audio_effect_mixer_if.master)
//   out_data/out_dv mixed frame and its 1-cycle strobe; out_data holds between strobes
//   busy          FSM not in IDLE
//   overrun       sticky: a frame arrived while busy and was dropped
//   timeout_err   sticky: a slot failed to answer within TIMEOUT WAIT cycles
// Optional feature: define AUDIO_MIX_TIMEOUT_EN to bound WAIT; otherwise WAIT is
// unbounded and timeout_err is tied low.
module audio_effect_mixer
  import audio_fx_pkg::*;
#(
  parameter int unsigned D_WIDTH     = 24,
  parameter int unsigned MEM_D_WIDTH = 16,
  parameter int unsigned N_CHANNELS  = 2,
  parameter int unsigned N_EFFECTS   = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_CHANNELS*D_WIDTH-1:0]   in_data,
  input  logic                            in_dv,
  input  logic [N_EFFECTS:0]              sel,
  audio_effect_mixer_if.master            fx,
  output logic [N_CHANNELS*D_WIDTH-1:0]   out_data,
  output logic                            out_dv,
  output logic                            busy,
  output logic                            overrun,
  output logic                            timeout_err
);

  localparam int unsigned ACC_W  = acc_width(MEM_D_WIDTH, N_EFFECTS);
  localparam int unsigned SLOT_W = N_CHANNELS * MEM_D_WIDTH;
  localparam int unsigned PAD_W  = D_WIDTH - MEM_D_WIDTH;

  state_t                              state_q, state_d;
  logic [N_EFFECTS:0]                  sel_q;
  logic [SLOT_W-1:0]                   eff_q;
  logic [N_EFFECTS-1:0]                pending_q;
  logic [N_EFFECTS*SLOT_W-1:0]         cap_q;

  logic [N_EFFECTS-1:0]                pend_eff, take, pend_next;
  logic                                to_hit;
  logic                                use_dry;
  logic [MEM_D_WIDTH-1:0]              dry;
  logic signed [ACC_W-1:0]             sum [N_CHANNELS];
  logic [D_WIDTH-1:0]                  sat_out [N_CHANNELS];

  // The I2S LSBs below the effect width are dropped by design.
  logic [N_CHANNELS*PAD_W-1:0]         lsb_bits;
  logic                                unused_lsbs;

  function automatic logic signed [ACC_W-1:0] sext(input logic [MEM_D_WIDTH-1:0] x);
    return {{(ACC_W - MEM_D_WIDTH){x[MEM_D_WIDTH-1]}}, x};
  endfunction

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_lsb
    assign lsb_bits[c*PAD_W +: PAD_W] = in_data[c*D_WIDTH +: PAD_W];
  end
  assign unused_lsbs = ^lsb_bits;

  assign fx.eff_data_in = eff_q;
  assign busy           = (state_q != IDLE);

  always_comb begin
    fx.eff_dv = '0;
    if (state_q == DISPATCH) begin
      fx.eff_dv = sel_q[N_EFFECTS:1];
    end
  end

  // In DISPATCH the pending register still holds the previous frame, so the
  // freshly selected mask is used directly; a done in that cycle already counts.
  always_comb begin
    pend_eff  = (state_q == DISPATCH) ? sel_q[N_EFFECTS:1] : pending_q;
    take      = '0;
    if (state_q == DISPATCH || state_q == WAIT) begin
      take = fx.eff_done & pend_eff;
    end
    pend_next = pend_eff & ~take;
  end

  // WAIT leaves on the same cycle the last pending done is seen, which gives
  // out_dv two cycles after the final eff_done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (in_dv) state_d = DISPATCH;
      DISPATCH: state_d = WAIT;
      WAIT:     if (pend_next == '0 || to_hit) state_d = MIX;
      MIX:      state_d = OUT;
      OUT:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Slots still pending after a timeout fall back to the dry sample, counted once.
  always_comb begin
    use_dry = sel_q[0] | (|pending_q);
    dry     = '0;
    for (int unsigned c = 0; c < N_CHANNELS; c++) begin
      dry    = eff_q[c*MEM_D_WIDTH +: MEM_D_WIDTH];
      sum[c] = use_dry ? sext(dry) : '0;
      for (int unsigned k = 0; k < N_EFFECTS; k++) begin
        if (sel_q[k+1] && !pending_q[k]) begin
          sum[c] = sum[c] + sext(cap_q[(k*N_CHANNELS + c)*MEM_D_WIDTH +: MEM_D_WIDTH]);
        end
      end
    end
  end

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_sat
    sat_trunc #(
      .D_WIDTH     (D_WIDTH),
      .MEM_D_WIDTH (MEM_D_WIDTH),
      .ACC_W       (ACC_W)
    ) u_sat (
      .acc (sum[c]),
      .out (sat_out[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      eff_q     <= '0;
      pending_q <= '0;
      cap_q     <= '0;
      out_data  <= '0;
      out_dv    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_dv  <= 1'b0;
      if (state_q == IDLE && in_dv) begin
        sel_q <= sel;
        for (int unsigned c = 0; c < N_CHANNELS; c++) begin
          eff_q[c*MEM_D_WIDTH +: MEM_D_WIDTH] <= in_data[c*D_WIDTH + PAD_W +: MEM_D_WIDTH];
        end
      end
      if (state_q != IDLE && in_dv) begin
        overrun <= 1'b1;
      end
      if (state_q == DISPATCH || state_q == WAIT) begin
        pending_q <= pend_next;
        for (int unsigned k = 0; k < N_EFFECTS; k++) begin
          if (take[k]) begin
            cap_q[k*SLOT_W +: SLOT_W] <= fx.eff_data_out[k*SLOT_W +: SLOT_W];
          end
        end
      end
      // Result registered on leaving MIX so it is presented during OUT.
      if (state_q == MIX) begin
        for (int unsigned c = 0; c < N_CHANNELS; c++) begin
          out_data[c*D_WIDTH +: D_WIDTH] <= sat_out[c];
        end
        out_dv <= 1'b1;
      end
    end
  end

`ifdef AUDIO_MIX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  assign to_hit = (state_q == WAIT) && (wait_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == DISPATCH) begin
        wait_cnt <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (to_hit && pend_next != '0) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_audio_effect_mixer.sv
// Directed, table-driven bench for audio_effect_mixer with default parameters.
module tb_audio_effect_mixer;

  localparam logic [9:0] NV = 10'h3FF;

  typedef struct {
    logic [4:0]       sel;
    logic [47:0]      din;
    logic [127:0]     slot;
    logic [3:0][9:0]  done_at;
    int               extra_dv;
    logic [47:0]      exp_out;
    int               exp_cyc;
    logic             exp_ovr;
    logic             exp_to;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [47:0]  in_data;
  logic         in_dv;
  logic [4:0]   sel;
  logic [47:0]  out_data;
  logic         out_dv;
  logic         busy;
  logic         overrun;
  logic         timeout_err;

  audio_effect_mixer_if #(.MEM_D_WIDTH(16), .N_CHANNELS(2), .N_EFFECTS(4)) fx ();

  audio_effect_mixer #(
    .D_WIDTH     (24),
    .MEM_D_WIDTH (16),
    .N_CHANNELS  (2),
    .N_EFFECTS   (4),
    .TIMEOUT     (255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_dv       (in_dv),
    .sel         (sel),
    .fx          (fx),
    .out_data    (out_data),
    .out_dv      (out_dv),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  vec_t        tbl [11];

  logic [47:0] got_out;
  int          got_cyc;
  int          pulses;
  logic [3:0]  effdv_first;
  int          effdv_cnt;
  logic        busy_after;
  logic        busy_last;

  task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] s, input logic [47:0] d, input logic [127:0] sl,
                              input logic [39:0] dn, input int x, input logic [47:0] eo,
                              input int ec, input logic ov, input logic to);
    vec_t v;
    v.sel = s; v.din = d; v.slot = sl; v.done_at = dn; v.extra_dv = x;
    v.exp_out = eo; v.exp_cyc = ec; v.exp_ovr = ov; v.exp_to = to;
    return v;
  endfunction

  // Cycle 0 carries in_dv; slot data is only meaningful while its done is high.
  task automatic run_frame(input vec_t v, input int budget);
    logic [3:0]   dn;
    logic [127:0] dat;
    got_cyc = -1; pulses = 0; effdv_first = '0; effdv_cnt = 0;
    got_out = '0; busy_after = 1'b1; busy_last = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      in_dv   = (k == 0) || (k == v.extra_dv);
      in_data = (k == 0) ? v.din : ~v.din;
      sel     = (k == 0) ? v.sel : ~v.sel;
      dn  = '0;
      dat = {8{16'hA5A5}};
      for (int s = 0; s < 4; s++) begin
        if (v.done_at[s] == 10'(k)) begin
          dn[s] = 1'b1;
          dat[s*32 +: 32] = v.slot[s*32 +: 32];
        end
      end
      fx.eff_done     = dn;
      fx.eff_data_out = dat;
      @(negedge clk);
      if (fx.eff_dv != '0) begin
        effdv_cnt++;
        if (k == 1) effdv_first = fx.eff_dv;
      end
      if (out_dv) begin
        pulses++;
        if (got_cyc < 0) begin
          got_cyc = k;
          got_out = out_data;
        end
      end
      if (got_cyc >= 0 && k == got_cyc + 1) busy_after = busy;
      busy_last = busy;
      if (got_cyc >= 0 && k == got_cyc + 6) break;
    end
    in_dv = 1'b0;
    fx.eff_done = '0;
  endtask

  task automatic apply(input int i);
    run_frame(tbl[i], tbl[i].exp_cyc + 8);
    chk("out_data", i, got_out, tbl[i].exp_out);
    chk("out_dv_cycle", i, got_cyc, tbl[i].exp_cyc);
    chk("out_dv_pulses", i, pulses, 1);
    chk("eff_dv_mask", i, effdv_first, tbl[i].sel[4:1]);
    chk("eff_dv_pulses", i, effdv_cnt, (tbl[i].sel[4:1] != 4'b0) ? 1 : 0);
    chk("busy_after", i, busy_after, 0);
    chk("out_hold", i, out_data, tbl[i].exp_out);
    chk("overrun", i, overrun, tbl[i].exp_ovr);
    chk("timeout_err", i, timeout_err, tbl[i].exp_to);
  endtask

  initial begin
    reset = 1'b1; in_dv = 1'b0; sel = '0; in_data = '0;
    fx.eff_done = '0; fx.eff_data_out = '0;

    // slot vector layout: {s3ch1,s3ch0,s2ch1,s2ch0,s1ch1,s1ch0,s0ch1,s0ch0}; done_at {s3,s2,s1,s0}
    tbl[0] = mk(5'b00001, {24'hFEDCBA, 24'h123456}, '0, {NV, NV, NV, NV}, -1,
                {24'hFEDC00, 24'h123400}, 4, 1'b0, 1'b0);
    tbl[1] = mk(5'b00011, {24'h000100, 24'h2000AA}, {96'h0, 16'h0002, 16'h7000},
                {NV, NV, NV, 10'd5}, -1, {24'h000300, 24'h7FFF00}, 7, 1'b0, 1'b0);
    tbl[2] = mk(5'b11110, {24'h123456, 24'h7FFFFF},
                {16'h8000, 16'h0004, 16'h8000, 16'h0003, 16'h8000, 16'h0002, 16'h8000, 16'h0001},
                {10'd9, 10'd4, 10'd6, 10'd3}, -1, {24'h800000, 24'h000A00}, 11, 1'b0, 1'b0);
    tbl[3] = mk(5'b00101, {24'h400000, 24'hFF0000},
                {64'h0, 16'h3FFF, 16'h0100, 16'h7FFF, 16'h7FFF},
                {NV, NV, 10'd2, 10'd2}, -1, {24'h7FFF00, 24'h000000}, 4, 1'b0, 1'b0);
    tbl[4] = mk(5'b00011, {24'h8001AB, 24'h800000}, {96'h0, 16'hFFFF, 16'hFFFF},
                {NV, NV, NV, 10'd3}, -1, {24'h800000, 24'h800000}, 5, 1'b0, 1'b0);
    tbl[5] = mk(5'b00000, {24'h111111, 24'h222222}, {8{16'h1234}},
                {10'd2, 10'd2, 10'd2, 10'd2}, -1, 48'h0, 4, 1'b0, 1'b0);
    tbl[6] = mk(5'b00001, {24'h0A0B0C, 24'hF0F0F0}, '0, {NV, NV, NV, NV}, 2,
                {24'h0A0B00, 24'hF0F000}, 4, 1'b1, 1'b0);
    tbl[7] = mk(5'b10001, {24'h001000, 24'h000200}, {16'h0020, 16'h0003, 96'h0},
                {10'd2, NV, NV, NV}, -1, {24'h003000, 24'h000500}, 4, 1'b1, 1'b0);
    tbl[8] = mk(5'b00001, {24'h765432, 24'h89ABCD}, '0, {NV, NV, NV, NV}, 4,
                {24'h765400, 24'h89AB00}, 4, 1'b1, 1'b0);
    tbl[9] = mk(5'b00011, {24'h200000, 24'h100000}, {96'h0, 16'h0001, 16'h0001},
                {NV, NV, NV, 10'd3}, -1, {24'h200100, 24'h100100}, 5, 1'b0, 1'b0);
    tbl[10] = mk(5'b00010, {24'hFEDCBA, 24'h123456}, {8{16'h4444}}, {NV, NV, NV, NV}, -1,
                 {24'hFEDC00, 24'h123400}, 2 + 255 + 2, 1'b0, 1'b1);

    // reset state
    #12;
    chk("rst_out_data", 0, out_data, 0);
    chk("rst_out_dv", 0, out_dv, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_overrun", 0, overrun, 0);
    chk("rst_timeout_err", 0, timeout_err, 0);
    chk("rst_eff_dv", 0, fx.eff_dv, 0);
    chk("rst_eff_data_in", 0, fx.eff_data_in, 0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 9; i++) apply(i);
    chk("eff_data_in_hold", 8, fx.eff_data_in, {16'h7654, 16'h89AB});

    // reset asserted while waiting on a slot
    @(posedge clk); #1;
    sel = 5'b00010; in_data = {24'h333333, 24'h444444}; in_dv = 1'b1;
    @(posedge clk); #1; in_dv = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_busy", 9, busy, 1);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    chk("mid_rst_busy", 9, busy, 0);
    chk("mid_rst_out_dv", 9, out_dv, 0);
    chk("mid_rst_out_data", 9, out_data, 0);
    chk("mid_rst_overrun", 9, overrun, 0);
    chk("mid_rst_eff_dv", 9, fx.eff_dv, 0);
    chk("mid_rst_eff_data_in", 9, fx.eff_data_in, 0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    fx.eff_done = 4'b0001; fx.eff_data_out = {8{16'h7FFF}};
    @(negedge clk);
    chk("stale_busy", 9, busy, 0);
    @(posedge clk); #1; fx.eff_done = '0;
    @(negedge clk);
    chk("stale_out_dv", 9, out_dv, 0);
    chk("stale_out_data", 9, out_data, 0);
    apply(9);

    // slot that never answers
`ifdef AUDIO_MIX_TIMEOUT_EN
    apply(10);
`else
    run_frame(tbl[10], 40);
    chk("hang_pulses", 10, pulses, 0);
    chk("hang_busy", 10, busy_last, 1);
    chk("hang_timeout_err", 10, timeout_err, 0);
    reset = 1'b1; #1;
    chk("hang_rst_busy", 10, busy, 0);
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
